// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU sequencer: function codes, lane widths,
// ALU opcode, FSM states and the per-function settle-class helper.
package alu_pkg;

    localparam logic [5:0] ALU_OPCODE = 6'b101010;

    localparam logic [5:0] VAND   = 6'd1;
    localparam logic [5:0] VOR    = 6'd2;
    localparam logic [5:0] VXOR   = 6'd3;
    localparam logic [5:0] VNOT   = 6'd4;
    localparam logic [5:0] VMOV   = 6'd5;
    localparam logic [5:0] VADD   = 6'd6;
    localparam logic [5:0] VSUB   = 6'd7;
    localparam logic [5:0] VMULEU = 6'd8;
    localparam logic [5:0] VMULOU = 6'd9;
    localparam logic [5:0] VSLL   = 6'd10;
    localparam logic [5:0] VSRL   = 6'd11;
    localparam logic [5:0] VSRA   = 6'd12;
    localparam logic [5:0] VRTTH  = 6'd13;
    localparam logic [5:0] VDIV   = 6'd14;
    localparam logic [5:0] VMOD   = 6'd15;
    localparam logic [5:0] VSQEU  = 6'd16;
    localparam logic [5:0] VSQOU  = 6'd17;
    localparam logic [5:0] VSQRT  = 6'd18;

    localparam logic [1:0] WW_8  = 2'b00;
    localparam logic [1:0] WW_16 = 2'b01;
    localparam logic [1:0] WW_32 = 2'b10;
    localparam logic [1:0] WW_64 = 2'b11;

    typedef enum logic [1:0] {LC_SIMPLE, LC_MUL, LC_DIV, LC_SQRT} lat_class_e;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    // Operand bundle held steady on the ALU inputs while it settles.
    typedef struct packed {
        logic [63:0] ra;
        logic [63:0] rb;
        logic [5:0]  func;
        logic [5:0]  opcode;
        logic [1:0]  ww;
    } alu_req_t;

    function automatic lat_class_e lat_class(input logic [5:0] func);
        case (func)
            VMULEU, VMULOU, VSQEU, VSQOU: return LC_MUL;
            VDIV, VMOD:                   return LC_DIV;
            VSQRT:                        return LC_SQRT;
            default:                      return LC_SIMPLE;
        endcase
    endfunction

endpackage

// File: rtl/alu_lat_lookup.sv
// Combinational decode of function/opcode into settle latency and an illegal-op flag.
module alu_lat_lookup
    import alu_pkg::*;
#(
    parameter int          LAT_SIMPLE = 1,
    parameter int          LAT_MUL    = 2,
    parameter int          LAT_DIV    = 6,
    parameter int          LAT_SQRT   = 6,
    parameter logic [5:0]  OPCODE     = ALU_OPCODE
) (
    input  logic [5:0] func,
    input  logic [5:0] opcode,
    output logic [3:0] lat,
    output logic       illegal
);

    always_comb begin
        illegal = (opcode != OPCODE) || (func == 6'd0) || (func > VSQRT);
        case (lat_class(func))
            LC_MUL:  lat = 4'(LAT_MUL);
            LC_DIV:  lat = 4'(LAT_DIV);
            LC_SQRT: lat = 4'(LAT_SQRT);
            default: lat = 4'(LAT_SIMPLE);
        endcase
        // Illegal ops report after a single cycle; lat-1 then loads zero.
        if (illegal)
            lat = 4'd1;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/settle/capture sequencer for the combinational SIMD ALU: one op in flight,
// operands held on the ALU for a per-class latency, result returned via valid/ready.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int          LAT_SIMPLE = 1,
    parameter int          LAT_MUL    = 2,
    parameter int          LAT_DIV    = 6,
    parameter int          LAT_SQRT   = 6,
    parameter logic [5:0]  OPCODE     = ALU_OPCODE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_rA,
    input  logic [63:0] in_rB,
    input  logic [5:0]  in_R_ins,
    input  logic [5:0]  in_Op_code,
    input  logic [1:0]  in_WW,
    output logic [63:0] alu_rA,
    output logic [63:0] alu_rB,
    output logic [5:0]  alu_R_ins,
    output logic [5:0]  alu_Op_code,
    output logic [1:0]  alu_WW,
    input  logic [63:0] alu_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic        out_err,
    output logic        busy
);

    if (LAT_SIMPLE < 1 || LAT_SIMPLE > 15 || LAT_MUL < 1 || LAT_MUL > 15 ||
        LAT_DIV < 1 || LAT_DIV > 15 || LAT_SQRT < 1 || LAT_SQRT > 15) begin : g_bad_lat
        $error("alu_issue_ctrl: every LAT_* parameter must be within 1..15");
    end

    state_e     state, state_nxt;
    alu_req_t   req_q;
    logic [3:0] cnt;
    logic       err_q;
    logic       accept;
    logic [3:0] lat;
    logic       illegal;

    alu_lat_lookup #(
        .LAT_SIMPLE (LAT_SIMPLE),
        .LAT_MUL    (LAT_MUL),
        .LAT_DIV    (LAT_DIV),
        .LAT_SQRT   (LAT_SQRT),
        .OPCODE     (OPCODE)
    ) u_lat (
        .func    (in_R_ins),
        .opcode  (in_Op_code),
        .lat     (lat),
        .illegal (illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: in_ready = !flush;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready && !flush;
            end
            default: ;
        endcase
        accept = in_valid && in_ready;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_nxt = EXEC;
                EXEC: if (cnt == 4'd0) state_nxt = DONE;
                DONE: if (out_ready) state_nxt = accept ? EXEC : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Operands, settle counter and result capture; operands move only on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q      <= '0;
            cnt        <= 4'd0;
            err_q      <= 1'b0;
            out_result <= 64'd0;
            out_err    <= 1'b0;
        end else if (flush) begin
            cnt <= 4'd0;
        end else begin
            if (accept) begin
                req_q <= '{ra: in_rA, rb: in_rB, func: in_R_ins, opcode: in_Op_code, ww: in_WW};
                cnt   <= lat - 4'd1;
                err_q <= illegal;
            end else if (state == EXEC && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == EXEC && cnt == 4'd0) begin
                out_result <= err_q ? 64'd0 : alu_out;
                out_err    <= err_q;
            end
        end
    end

    assign alu_rA      = req_q.ra;
    assign alu_rB      = req_q.rb;
    assign alu_R_ins   = req_q.func;
    assign alu_Op_code = req_q.opcode;
    assign alu_WW      = req_q.ww;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus randomized ops
// against a behavioural ALU/latency reference.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_rA, in_rB;
    logic [5:0]  in_R_ins, in_Op_code;
    logic [1:0]  in_WW;
    logic [63:0] alu_rA, alu_rB;
    logic [5:0]  alu_R_ins, alu_Op_code;
    logic [1:0]  alu_WW;
    logic [63:0] alu_out;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_err;
    logic        busy;

    int errs   = 0;
    int checks = 0;

    localparam logic [5:0] OPC = 6'b101010;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rA(in_rA), .in_rB(in_rB), .in_R_ins(in_R_ins), .in_Op_code(in_Op_code), .in_WW(in_WW),
        .alu_rA(alu_rA), .alu_rB(alu_rB), .alu_R_ins(alu_R_ins), .alu_Op_code(alu_Op_code),
        .alu_WW(alu_WW), .alu_out(alu_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; lane 0 is the most significant lane.
    function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic [5:0] f, input logic [1:0] ww);
        int          w;
        int          sh;
        logic [63:0] r, m, la, lb, v;
        w = 8 << ww;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        r = 64'd0;
        case (f)
            6'd1: return a & b;
            6'd2: return a | b;
            6'd3: return a ^ b;
            6'd4: return ~a;
            6'd5: return a;
            6'd6, 6'd7, 6'd8, 6'd9, 6'd14, 6'd15: begin
                for (int k = 0; k < 64 / w; k++) begin
                    sh = 64 - (k + 1) * w;
                    la = (a >> sh) & m;
                    lb = (b >> sh) & m;
                    case (f)
                        6'd6:  r |= ((la + lb) & m) << sh;
                        6'd7:  r |= ((la - lb) & m) << sh;
                        6'd14: r |= ((lb == 0) ? 64'd0 : (la / lb)) << sh;
                        6'd15: r |= ((lb == 0) ? 64'd0 : (la % lb)) << sh;
                        default: begin
                            // widening multiply of even (8) or odd (9) lanes into a lane pair
                            v = la * lb;
                            if (w == 64) begin
                                if (f == 6'd8) r = v;
                            end else if ((k % 2 == 0) && f == 6'd8) begin
                                r |= v << (64 - (k + 2) * w);
                            end else if ((k % 2 == 1) && f == 6'd9) begin
                                r |= v << (64 - (k + 1) * w);
                            end
                        end
                    endcase
                end
                return r;
            end
            default: return a ^ {b[31:0], b[63:32]} ^ {58'd0, f};
        endcase
    endfunction

    assign alu_out = alu_model(alu_rA, alu_rB, alu_R_ins, alu_WW);

    function automatic bit is_illegal(input logic [5:0] f, input logic [5:0] op);
        return (op != OPC) || (f == 6'd0) || (f > 6'd18);
    endfunction

    function automatic int exp_lat(input logic [5:0] f, input logic [5:0] op);
        if (is_illegal(f, op)) return 1;
        if (f inside {6'd8, 6'd9, 6'd16, 6'd17}) return 2;
        if (f inside {6'd14, 6'd15, 6'd18}) return 6;
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an op at a negedge and return just after the accepting posedge.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [5:0] f,
                        input logic [5:0] op, input logic [1:0] ww, output bit ok);
        ok = 1'b0;
        in_rA = a; in_rB = b; in_R_ins = f; in_Op_code = op; in_WW = ww;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
    endtask

    // Wait for out_valid, checking latency, result, error flag and operand hold.
    task automatic wait_result(input string tag, input logic [63:0] a, input logic [63:0] b,
                               input logic [5:0] f, input logic [5:0] op, input logic [1:0] ww);
        int k = 0;
        bit moved = 1'b0;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if ({alu_rA, alu_rB, alu_R_ins, alu_Op_code, alu_WW} !== {a, b, f, op, ww}) moved = 1'b1;
        while (!out_valid && k < 30) begin
            @(negedge clk);
            k++;
            if ({alu_rA, alu_rB, alu_R_ins, alu_Op_code, alu_WW} !== {a, b, f, op, ww}) moved = 1'b1;
        end
        chk({tag, "_lat"}, 64'(k), 64'(exp_lat(f, op)));
        chk({tag, "_res"}, out_result, is_illegal(f, op) ? 64'd0 : alu_model(a, b, f, ww));
        chk({tag, "_err"}, 64'(out_err), 64'(is_illegal(f, op)));
        chk({tag, "_hold"}, 64'(moved), 64'd0);
    endtask

    // Hold off the result bp cycles, then handshake.
    task automatic finish_hs(input string tag, input int bp);
        logic [63:0] r;
        bit          unstable = 1'b0;
        r = out_result;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (!out_valid || out_result !== r || in_ready) unstable = 1'b1;
        end
        chk({tag, "_bp"}, 64'(unstable), 64'd0);
        out_ready = 1'b1;
        #1;
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        chk({tag, "_drop"}, 64'(out_valid), 64'd0);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [5:0] f, input logic [5:0] op, input logic [1:0] ww,
                          input int bp);
        bit ok;
        send(a, b, f, op, ww, ok);
        if (!ok) return;
        wait_result(tag, a, b, f, op, ww);
        finish_hs(tag, bp);
    endtask

    initial begin
        bit          ok;
        bit          seen;
        logic [63:0] r, ra, rb;
        logic [5:0]  f, op;
        logic [1:0]  ww;

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_rA = '0; in_rB = '0; in_R_ins = '0; in_Op_code = '0; in_WW = '0;
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(out_err), 64'd0);
        chk("rst_alu_rA", alu_rA, 64'd0);
        chk("rst_result", out_result, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // 1: VADD, 64-bit lane
        run_op("t1", 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_11111111, 6'd6, OPC, 2'b11, 0);
        chk("t1_const", out_result, 64'h00000000_11111110);

        // 2: VDIV, 8-bit lanes, six-cycle settle
        run_op("t2", 64'hFF00FF00_FF00FF00, 64'h11221122_44444444, 6'd14, OPC, 2'b00, 0);

        // 3: wrong opcode
        run_op("t3", 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 6'd1, 6'd0, 2'b11, 0);

        // 4: back-to-back, second accept on the first handshake edge
        send(64'd15, 64'd14, 6'd1, OPC, 2'b11, ok);
        wait_result("t4a", 64'd15, 64'd14, 6'd1, OPC, 2'b11);
        chk("t4a_const", out_result, 64'h0E);
        in_rA = 64'd15; in_rB = 64'd14; in_R_ins = 6'd2; in_Op_code = OPC; in_WW = 2'b11;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("t4_b2b_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        wait_result("t4b", 64'd15, 64'd14, 6'd2, OPC, 2'b11);
        chk("t4b_const", out_result, 64'h0F);
        finish_hs("t4b", 0);

        // 5: flush mid-VSQRT, new request presented during flush must be ignored
        send(64'h12345678_9ABCDEF0, 64'd0, 6'd18, OPC, 2'b10, ok);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        in_rA = 64'd7; in_R_ins = 6'd1; in_valid = 1'b1;
        #1;
        chk("t5_ready_flush", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_no_accept", 64'(alu_R_ins), 64'd18);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("t5_no_valid", 64'(seen), 64'd0);
        run_op("t5n", 64'h0102030405060708, 64'h0101010101010101, 6'd7, OPC, 2'b00, 0);

        // 6: backpressure with a competing request held off
        send(64'hFF000000_FFFFFFFF, 64'h00020000_000F0001, 6'd8, OPC, 2'b01, ok);
        wait_result("t6", 64'hFF000000_FFFFFFFF, 64'h00020000_000F0001, 6'd8, OPC, 2'b01);
        r = out_result;
        in_rA = 64'd3; in_rB = 64'd5; in_R_ins = 6'd1; in_Op_code = OPC; in_WW = 2'b11;
        in_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!out_valid || out_result !== r || in_ready || alu_R_ins !== 6'd8) seen = 1'b1;
        end
        chk("t6_stall", 64'(seen), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("t6_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        wait_result("t6b", 64'd3, 64'd5, 6'd1, OPC, 2'b11);
        finish_hs("t6b", 1);

        // Reset in the middle of a divide
        send(64'hDEADBEEF_00C0FFEE, 64'h00000003_00000007, 6'd14, OPC, 2'b10, ok);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst2_busy", 64'(busy), 64'd0);
        chk("rst2_valid", 64'(out_valid), 64'd0);
        chk("rst2_alu_rA", alu_rA, 64'd0);
        chk("rst2_func", 64'(alu_R_ins), 64'd0);
        chk("rst2_result", out_result, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst2_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Randomized ops with occasional bad opcodes and random backpressure
        for (int n = 0; n < 40; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            f  = 6'($urandom_range(0, 20));
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : OPC;
            ww = 2'($urandom);
            run_op("rnd", ra, rb, f, op, ww, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
